// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the MIPS-subset multicycle control
// Purpose: state encodings, opcode constants and datapath select codes shared
//          by the main control FSM and the ALU control decoder.
// Ports:   none (package).
package mips_ctrl_pkg;

   localparam int unsigned OPC_W = 6;
   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REXEC  = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_e;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore main control FSM for the multicycle MIPS datapath
// Purpose: sequences each instruction through fetch/decode/execute/memory/
//          writeback and drives every datapath enable and mux select.
// Ports:   clk, rst_n (async, active low); Opcode (IR[31:26]); Zero (unused
//          here, gated by the datapath with PCWriteCond); MemReady (memory
//          handshake); IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
//          RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond
//          (datapath controls); State (debug view of the state register).
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W = 6,
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] Opcode,
   input  logic            Zero,
   input  logic            MemReady,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            RegDst,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [2:0]      ALUOp,
   output logic [1:0]      PCSrc,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic [ST_W-1:0] State
);

   state_e state_q, state_d;

   // Zero is ANDed with PCWriteCond outside this block.
   logic unused_zero;
   assign unused_zero = Zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEMADR;
            else if (Opcode == OP_RTYPE)            state_d = S_REXEC;
            else if (Opcode == OP_BEQ)              state_d = S_BEQ;
            else if (Opcode == OP_ADDI)             state_d = S_ADDIEX;
            else if (Opcode == OP_J)                state_d = S_JUMP;
            else                                    state_d = S_FETCH; // NOP
         end
         // IR is stable here, so re-sampling the opcode is safe.
         S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (MemReady) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (MemReady) state_d = S_FETCH;
         S_REXEC:  state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output decode: purely from state, except the FETCH write enables,
   // which only fire in the cycle the instruction word actually arrives.
   always_comb begin
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALUOP_ADD;
      PCSrc       = PCSRC_ALU;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE: ALUSrcB = SRCB_IMMSL2;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_REXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_RTYPE;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSrc       = PCSRC_ALUOUT;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign State = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] Opcode;
   logic       Zero;
   logic       MemReady;
   logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUOp;
   logic       PCWrite, PCWriteCond;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   logic [20:0] exp_q[$];
   int          tag_q[$];

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .State(State)
   );

   always #5 clk = ~clk;

   // {State, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
   //  ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond}
   function automatic logic [20:0] mk(input int st, input bit iord, input bit mrd,
                                      input bit mwr, input bit irw, input bit rdst,
                                      input bit m2r, input bit rw, input bit srca,
                                      input int srcb, input int aop, input int pcs,
                                      input bit pcw, input bit pcc);
      logic [3:0] s4;
      logic [1:0] b2, p2;
      logic [2:0] a3;
      s4 = st[3:0];
      b2 = srcb[1:0];
      a3 = aop[2:0];
      p2 = pcs[1:0];
      return {s4, iord, mrd, mwr, irw, rdst, m2r, rw, srca, b2, a3, p2, pcw, pcc};
   endfunction

   logic [20:0] E_IDLE, E_FRDY, E_FWAIT, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR;
   logic [20:0] E_REX, E_RWB, E_BEQ, E_AEX, E_AWB, E_JMP;

   initial begin
      //           st iord mrd mwr irw rdst m2r rw srca srcb aop pcs pcw pcc
      E_IDLE  = mk(0,  0,   0,  0,  0,  0,   0,  0, 0,   0,   0,  0,  0,  0);
      E_FRDY  = mk(1,  0,   1,  0,  1,  0,   0,  0, 0,   1,   0,  0,  1,  0);
      E_FWAIT = mk(1,  0,   1,  0,  0,  0,   0,  0, 0,   1,   0,  0,  0,  0);
      E_DEC   = mk(2,  0,   0,  0,  0,  0,   0,  0, 0,   3,   0,  0,  0,  0);
      E_MADR  = mk(3,  0,   0,  0,  0,  0,   0,  0, 1,   2,   0,  0,  0,  0);
      E_MRD   = mk(4,  1,   1,  0,  0,  0,   0,  0, 0,   0,   0,  0,  0,  0);
      E_MWB   = mk(5,  0,   0,  0,  0,  0,   1,  1, 0,   0,   0,  0,  0,  0);
      E_MWR   = mk(6,  1,   0,  1,  0,  0,   0,  0, 0,   0,   0,  0,  0,  0);
      E_REX   = mk(7,  0,   0,  0,  0,  0,   0,  0, 1,   0,   2,  0,  0,  0);
      E_RWB   = mk(8,  0,   0,  0,  0,  1,   0,  1, 0,   0,   0,  0,  0,  0);
      E_BEQ   = mk(9,  0,   0,  0,  0,  0,   0,  0, 1,   0,   1,  1,  0,  1);
      E_AEX   = mk(10, 0,   0,  0,  0,  0,   0,  0, 1,   2,   0,  0,  0,  0);
      E_AWB   = mk(11, 0,   0,  0,  0,  0,   0,  1, 0,   0,   0,  0,  0,  0);
      E_JMP   = mk(12, 0,   0,  0,  0,  0,   0,  0, 0,   0,   0,  2,  1,  0);
   end

   // Monitor: outputs are valid every cycle; sample mid-cycle on the falling edge.
   always @(negedge clk) begin
      logic [20:0] act, expv;
      int tag;
      if (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         tag  = tag_q.pop_front();
         act  = {State, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond};
         checks++;
         if (act !== expv) begin
            errors++;
            $display("FAIL step%0d: outputs got %h required %h (state got %0d required %0d)",
                     tag, act, expv, act[20:17], expv[20:17]);
         end
      end
   end

   // One cycle of stimulus: drive inputs just after the rising edge and queue
   // the outputs expected for that cycle.
   task automatic step(input bit rst, input bit mr, input logic [5:0] op,
                       input logic [20:0] expv);
      rst_n    = rst;
      MemReady = mr;
      Opcode   = op;
      exp_q.push_back(expv);
      tag_q.push_back(step_no);
      step_no++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      MemReady = 1'b1;
      Opcode   = 6'b000000;
      Zero     = 1'b0;
      @(posedge clk);
      #1;
      // reset held 3 cycles, then release
      repeat (3) step(0, 1, 6'b000000, E_IDLE);
      step(1, 1, 6'b000000, E_IDLE);
      // R-type, with MemReady low in DECODE to show it is ignored there
      step(1, 1, 6'b000000, E_FRDY);
      step(1, 0, 6'b000000, E_DEC);
      step(1, 1, 6'b000000, E_REX);
      step(1, 1, 6'b000000, E_RWB);
      // lw with two wait cycles in MEMRD (7 cycles)
      step(1, 1, 6'b100011, E_FRDY);
      step(1, 1, 6'b100011, E_DEC);
      step(1, 1, 6'b100011, E_MADR);
      step(1, 0, 6'b100011, E_MRD);
      step(1, 0, 6'b100011, E_MRD);
      step(1, 1, 6'b100011, E_MRD);
      step(1, 1, 6'b100011, E_MWB);
      // beq, with one fetch wait cycle first
      step(1, 0, 6'b000100, E_FWAIT);
      step(1, 1, 6'b000100, E_FRDY);
      step(1, 1, 6'b000100, E_DEC);
      step(1, 1, 6'b000100, E_BEQ);
      // addi
      step(1, 1, 6'b001000, E_FRDY);
      step(1, 1, 6'b001000, E_DEC);
      step(1, 1, 6'b001000, E_AEX);
      step(1, 1, 6'b001000, E_AWB);
      // j
      step(1, 1, 6'b000010, E_FRDY);
      step(1, 1, 6'b000010, E_DEC);
      step(1, 1, 6'b000010, E_JMP);
      // undefined opcode: DECODE straight back to FETCH
      step(1, 1, 6'b111111, E_FRDY);
      step(1, 1, 6'b111111, E_DEC);
      // sw, no wait
      step(1, 1, 6'b101011, E_FRDY);
      step(1, 1, 6'b101011, E_DEC);
      step(1, 1, 6'b101011, E_MADR);
      step(1, 1, 6'b101011, E_MWR);
      // sw stuck waiting, then reset mid-wait
      step(1, 1, 6'b101011, E_FRDY);
      step(1, 1, 6'b101011, E_DEC);
      step(1, 1, 6'b101011, E_MADR);
      step(1, 0, 6'b101011, E_MWR);
      step(1, 0, 6'b101011, E_MWR);
      step(0, 0, 6'b101011, E_IDLE);
      step(0, 1, 6'b101011, E_IDLE);
      // recovery after reset
      step(1, 1, 6'b000000, E_IDLE);
      step(1, 1, 6'b000000, E_FRDY);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending expectations got %0d required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control unit for the MIPS-subset datapath. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and produces the 3-bit `ALUOp` consumed by the ALU control decoder. Memory accesses wait on a ready handshake, so variable-latency memories can be used.

## Interface
Parameters:
- `OP_W`, default 6: opcode width.
- `ST_W`, default 4: state register width.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Opcode` in 6: `IR[31:26]`, valid from DECODE onward.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory has completed the current read or write this cycle.
- `IorD` out 1: memory address source (0 = PC, 1 = ALUOut).
- `MemRead`, `MemWrite` out 1 each: memory access strobes.
- `IRWrite` out 1: instruction register load.
- `RegDst`, `MemtoReg`, `RegWrite` out 1 each: register file controls.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `ALUOp` out 3: 000 = add, 001 = sub, 010 = R-type (decode `funct`).
- `PCSrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load gated by `Zero`.
- `State` out 4: current state, for debug.

## Operation
States:
- IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, BEQ=9, ADDIEX=10, ADDIWB=11, JUMP=12.

Opcodes:
- R-type = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.

Per-state outputs. Anything not listed is 0, and `ALUOp` defaults to 000.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=000, `PCSrc`=00.
  - `IRWrite` and `PCWrite` equal `MemReady`.
  - Stay in FETCH while `MemReady`=0; go to DECODE when it is 1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=000 (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → REXEC
  - beq → BEQ
  - addi → ADDIEX
  - j → JUMP
  - any other opcode → FETCH (executes as a NOP)
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=000. Next is MEMRD for lw, MEMWR for sw. The opcode is re-sampled here; `IR` is stable.
- MEMRD: `MemRead`=1, `IorD`=1. Stay until `MemReady`=1, then MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Next is FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Stay until `MemReady`=1, then FETCH.
- REXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=010. Next is RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next is FETCH.
- BEQ: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=001, `PCWriteCond`=1, `PCSrc`=01. Next is FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=000. Next is ADDIWB.
- ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next is FETCH.
- JUMP: `PCWrite`=1, `PCSrc`=10. Next is FETCH.

## Timing
- Reset: asserting `rst_n`=0 forces IDLE immediately and asynchronously, so all outputs are 0 and `State`=0. This includes reset mid-instruction and mid-wait.
- After `rst_n` is released, the first rising edge moves to FETCH.
- Outputs are decoded combinationally from the state register. Only the FETCH write enables are additionally qualified by `MemReady`.
- `MemRead` and `MemWrite` are held steady for the whole wait, whatever its length. No timeout.
- Minimum cycles per instruction, with `MemReady` always 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - undefined opcode: 2
- Each extra memory wait cycle adds 1 cycle.
- `MemReady` seen outside FETCH, MEMRD or MEMWR is ignored.
- `Zero` is consumed only in BEQ; the datapath ANDs it with `PCWriteCond`.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings
  - opcode constants
  - `ALUOp` codes (000/001/010, shared with the ALU control decoder)
  - `ALUSrcB` and `PCSrc` select codes
- Single module: a state register, a next-state block and an output-decode block. No sub-module is needed.

## Test plan
- Reset and fetch: hold `rst_n`=0 for 3 cycles, then release with `MemReady`=1.
  - During reset, all outputs are 0 and `State`=0.
  - The next cycle is `State`=1 with `MemRead`=1, `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=01.
- R-type (`Opcode`=000000): sequence 1→2→7→8→1. `ALUOp`=010 in state 7; `RegWrite`=1 and `RegDst`=1 in state 8.
- lw with waits (`Opcode`=100011, `MemReady`=0 for 2 cycles in MEMRD): `State` holds at 4 for 3 cycles with `MemRead`=1 and `IorD`=1, then state 5 shows `MemtoReg`=1 and `RegWrite`=1. Total is 7 cycles.
- beq (`Opcode`=000100): state 9 shows `ALUOp`=001, `PCWriteCond`=1, `PCSrc`=01, then returns to 1.
- j and undefined opcode:
  - j (000010): state 12 shows `PCWrite`=1 and `PCSrc`=10.
  - Opcode 111111: goes DECODE→FETCH with no `RegWrite` or `MemWrite` pulse.
- Mid-wait reset: in MEMWR with `MemReady`=0, drop `rst_n`. `MemWrite` falls to 0 the same cycle and `State`=0.
